// File: rtl/line_memory_responder_pkg.sv
// Shared definitions for the dcache line memory port: responder state encoding
// and the cache line geometry (also used by dcache_top).
package line_memory_responder_pkg;

    localparam int LINE_W = 256;
    localparam int OFF_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/line_ram.sv
// Single-port line storage: synchronous write, registered read.
// The array is named 'memory' so testbenches can preload and inspect it.
module line_ram #(
    parameter int DEPTH  = 512,
    parameter int LINE_W = line_memory_responder_pkg::LINE_W,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] memory [DEPTH];
    logic [LINE_W-1:0] rdata_d;
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memory[idx_i] <= wdata_i;
        end
    end

    // Read register holds the last line read until another read replaces it.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = memory[idx_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory_responder.sv
// Fixed-latency off-chip line memory model for the dcache fill/write-back port.
// One request at a time: accept in IDLE, wait in BUSY, pulse ack in ACK.
module line_memory_responder #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int LINE_W  = line_memory_responder_pkg::LINE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);
    import line_memory_responder_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic                ack_q, ack_d;

    logic                enter_ack;
    logic [IDX_W-1:0]    req_index;
    logic [LINE_W-1:0]   req_data;
    logic                req_write;

    wire unused_addr = ^{addr_i[OFF_W-1:0], addr_i[31:OFF_W+IDX_W]};

    // With LATENCY == 1 the ACK edge is the accept edge, so the RAM must be
    // fed straight from the inputs instead of the not-yet-loaded latches.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        enter_ack = 1'b0;
        req_index = index_q;
        req_data  = wdata_q;
        req_write = write_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    index_d   = addr_i[OFF_W +: IDX_W];
                    wdata_d   = data_i;
                    write_d   = write_i;
                    count_d   = CNT_W'(1);
                    req_index = addr_i[OFF_W +: IDX_W];
                    req_data  = data_i;
                    req_write = write_i;
                    if (LATENCY == 1) begin
                        state_d   = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(LATENCY - 1)) begin
                    state_d   = ST_ACK;
                    enter_ack = 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        ack_d = enter_ack;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            index_q <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            ack_q   <= ack_d;
        end
    end

    line_ram #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (enter_ack & req_write),
        .re_i    (enter_ack & ~req_write),
        .idx_i   (req_index),
        .wdata_i (req_data),
        .rdata_o (data_o)
    );

    assign ack_o = ack_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed self-checking bench for line_memory_responder (LATENCY 10 and 1).
module tb_line_memory_responder;
    import line_memory_responder_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       addr;
    logic [LINE_W-1:0] data_in;
    logic              enable;
    logic              write;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;

    logic [31:0]       addr1;
    logic [LINE_W-1:0] data_in1;
    logic              enable1;
    logic              write1;
    logic              ack1;
    logic [LINE_W-1:0] data_o1;

    int checks = 0;
    int errors = 0;

    localparam logic [LINE_W-1:0] PAT_A5  = {32{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_WR4 = 256'h1234;
    localparam logic [LINE_W-1:0] PAT_L0  = {8{32'h0F0F_0000}};
    localparam logic [LINE_W-1:0] PAT_L7  = {8{32'h7777_0007}};
    localparam logic [LINE_W-1:0] PAT_NEW = {8{32'hDEAD_BEEF}};
    localparam logic [LINE_W-1:0] PAT_L8  = {8{32'h8888_0008}};
    localparam logic [LINE_W-1:0] PAT_L9  = {8{32'h9999_0009}};
    localparam logic [LINE_W-1:0] PAT_L2  = {8{32'h2222_0002}};
    localparam logic [LINE_W-1:0] PAT_W5  = {8{32'h5555_AAAA}};

    always #5 clk = ~clk;

    line_memory_responder #(.LATENCY(10), .DEPTH(512), .LINE_W(LINE_W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (addr),
        .data_i   (data_in),
        .enable_i (enable),
        .write_i  (write),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    line_memory_responder #(.LATENCY(1), .DEPTH(512), .LINE_W(LINE_W)) dut1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (addr1),
        .data_i   (data_in1),
        .enable_i (enable1),
        .write_i  (write1),
        .ack_o    (ack1),
        .data_o   (data_o1)
    );

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Starts cycle 0 of a request on the main DUT.
    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [LINE_W-1:0] d);
        @(posedge clk);
        #1;
        enable  = 1'b1;
        write   = wr;
        addr    = a;
        data_in = d;
    endtask

    // Returns the cycle number of the first ack, or -1 if none within budget.
    task automatic wait_ack(input int budget, input int churn_cycle, input logic [31:0] churn_addr,
                            output int ack_cycle);
        ack_cycle = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (c == churn_cycle) begin
                enable  = 1'b0;
                addr    = churn_addr;
                data_in = ~data_in;
            end else if (churn_cycle == 0 && c == 1) begin
                enable = 1'b0;
            end
            if (ack_o === 1'b1) begin
                ack_cycle = c;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ac;
        rst      = 1'b1;
        enable   = 1'b0;
        write    = 1'b0;
        addr     = '0;
        data_in  = '0;
        enable1  = 1'b0;
        write1   = 1'b0;
        addr1    = '0;
        data_in1 = '0;
        #1;
        dut.u_ram.memory[0]  = PAT_L0;
        dut.u_ram.memory[3]  = PAT_A5;
        dut.u_ram.memory[4]  = '0;
        dut.u_ram.memory[7]  = PAT_L7;
        dut.u_ram.memory[8]  = PAT_L8;
        dut.u_ram.memory[9]  = PAT_L9;
        dut1.u_ram.memory[2] = PAT_L2;
        dut1.u_ram.memory[5] = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ack", LINE_W'(ack_o), '0);
        checkOutput("reset_data", data_o, '0);
        rst = 1'b0;

        applyStimulus(1'b0, 32'h60, '0);
        wait_ack(20, 0, 32'h0, ac);
        checkOutput("read_ack_cycle", LINE_W'(ac), LINE_W'(10));
        checkOutput("read_data", data_o, PAT_A5);
        @(posedge clk);
        #1;
        checkOutput("read_ack_single", LINE_W'(ack_o), '0);
        checkOutput("read_data_held", data_o, PAT_A5);

        applyStimulus(1'b1, 32'h80, PAT_WR4);
        wait_ack(20, 0, 32'h0, ac);
        checkOutput("write_ack_cycle", LINE_W'(ac), LINE_W'(10));
        checkOutput("write_data_o_unchanged", data_o, PAT_A5);
        checkOutput("write_committed", dut.u_ram.memory[4], PAT_WR4);
        applyStimulus(1'b0, 32'h9F, PAT_NEW);
        checkOutput("b2b_no_double_ack", LINE_W'(ack_o), '0);
        wait_ack(20, 0, 32'h0, ac);
        checkOutput("b2b_read_ack_cycle", LINE_W'(ac), LINE_W'(10));
        checkOutput("b2b_read_data", data_o, PAT_WR4);

        applyStimulus(1'b0, 32'h100, '0);
        wait_ack(20, 4, 32'h120, ac);
        checkOutput("churn_ack_cycle", LINE_W'(ac), LINE_W'(10));
        checkOutput("churn_data", data_o, PAT_L8);

        applyStimulus(1'b0, 32'h4000, '0);
        wait_ack(20, 0, 32'h0, ac);
        checkOutput("wrap_ack_cycle", LINE_W'(ac), LINE_W'(10));
        checkOutput("wrap_data", data_o, PAT_L0);

        applyStimulus(1'b1, 32'hE0, PAT_NEW);
        wait_ack(4, 0, 32'h0, ac);
        checkOutput("abort_no_early_ack", LINE_W'(ac), {LINE_W{1'b1}});
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("abort_ack_low", LINE_W'(ack_o), '0);
        checkOutput("abort_data_cleared", data_o, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ack(15, 0, 32'h0, ac);
        checkOutput("abort_no_ack", LINE_W'(ac), {LINE_W{1'b1}});
        checkOutput("abort_line7_intact", dut.u_ram.memory[7], PAT_L7);
        applyStimulus(1'b0, 32'hE0, '0);
        wait_ack(20, 0, 32'h0, ac);
        checkOutput("after_abort_read", data_o, PAT_L7);

        applyStimulus(1'b0, 32'h60, '0);
        wait_ack(20, 0, 32'h0, ac);
        checkOutput("ackreset_ack_cycle", LINE_W'(ac), LINE_W'(10));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_ack", LINE_W'(ack_o), '0);
        checkOutput("async_reset_data", data_o, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_line3_intact", dut.u_ram.memory[3], PAT_A5);

        @(posedge clk);
        #1;
        enable1 = 1'b1;
        write1  = 1'b0;
        addr1   = 32'h40;
        @(posedge clk);
        #1;
        enable1 = 1'b0;
        checkOutput("lat1_read_ack", LINE_W'(ack1), LINE_W'(1));
        checkOutput("lat1_read_data", data_o1, PAT_L2);
        enable1  = 1'b1;
        write1   = 1'b1;
        addr1    = 32'hA0;
        data_in1 = PAT_W5;
        @(posedge clk);
        #1;
        checkOutput("lat1_ack_in_ack_ignored", LINE_W'(ack1), '0);
        @(posedge clk);
        #1;
        enable1 = 1'b0;
        checkOutput("lat1_write_ack", LINE_W'(ack1), LINE_W'(1));
        checkOutput("lat1_write_data_o_held", data_o1, PAT_L2);
        @(posedge clk);
        #1;
        enable1 = 1'b1;
        write1  = 1'b0;
        addr1   = 32'hA0;
        @(posedge clk);
        #1;
        enable1 = 1'b0;
        checkOutput("lat1_readback_ack", LINE_W'(ack1), LINE_W'(1));
        checkOutput("lat1_readback_data", data_o1, PAT_W5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
